// File: rtl/key_debounce_us_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key debouncer.
//   - DEBOUNCE_US_DEFAULT : default number of stable 1 us ticks needed to
//                           accept a level change (20 ms at 1 MHz).
//   - key_state_e         : filter FSM state encoding.
// -----------------------------------------------------------------------------
package key_pkg;

    localparam int DEBOUNCE_US_DEFAULT = 20000;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,  // stable released
        ST_PRESS_FILT   = 2'd1,  // key looks pressed, counting stable ticks
        ST_DOWN         = 2'd2,  // stable pressed
        ST_RELEASE_FILT = 2'd3   // key looks released, counting stable ticks
    } key_state_e;

endpackage : key_pkg

// File: rtl/key_debounce_us_if.sv
// -----------------------------------------------------------------------------
// key_debounce_us_if
// Bundles the debouncer's non-clock signals.
//   clk_1m      : 1 MHz divider output, synchronous to clk (50 % duty)
//   key_in      : raw button, active-low, asynchronous
//   key_level   : debounced state, 1 = pressed
//   key_press   : one-cycle strobe on accepted press
//   key_release : one-cycle strobe on accepted release
// Modports: master = stimulus / consumer side, slave = debouncer side.
// -----------------------------------------------------------------------------
interface key_debounce_us_if;

    logic clk_1m;
    logic key_in;
    logic key_level;
    logic key_press;
    logic key_release;

    modport master (
        output clk_1m,
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  clk_1m,
        input  key_in,
        output key_level,
        output key_press,
        output key_release
    );

endinterface : key_debounce_us_if

// File: rtl/key_debounce_us_tick_edge.sv
// -----------------------------------------------------------------------------
// tick_edge
// Rising-edge detector: turns a slow square wave that is synchronous to clk
// (e.g. the 1 MHz divider output) into a single-cycle tick.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   level_in : slow square wave input
//   tick     : high for the one clk cycle in which level_in first reads 1
// -----------------------------------------------------------------------------
module tick_edge (
    input  logic clk,
    input  logic rst,
    input  logic level_in,
    output logic tick
);

    logic level_q;
    logic level_d;

    assign level_d = level_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign tick = level_in & ~level_q;

endmodule : tick_edge

// File: rtl/key_debounce_us.sv
// -----------------------------------------------------------------------------
// key_debounce_us
// Debounces one active-low push button against a 1 us time base.
// A level change is accepted only after DEBOUNCE_US consecutive 1 us ticks
// during which the synchronized key never reverted. DEBOUNCE_US must be >= 2.
//   clk    : 100 MHz system clock
//   rst    : synchronous active-high reset
//   key_if : slave side of key_debounce_us_if (clk_1m, key_in in;
//            key_level, key_press, key_release out, all registered)
// -----------------------------------------------------------------------------
module key_debounce_us
    import key_pkg::*;
#(
    parameter int DEBOUNCE_US = DEBOUNCE_US_DEFAULT,
    parameter int CNT_W       = $clog2(DEBOUNCE_US)
) (
    input  logic             clk,
    input  logic             rst,
    key_debounce_us_if.slave key_if
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_US - 1);

    logic tick;

    tick_edge u_tick_edge (
        .clk      (clk),
        .rst      (rst),
        .level_in (key_if.clk_1m),
        .tick     (tick)
    );

    // Two-flop synchronizer; resets to 1 so a reset looks like "released".
    logic [1:0] sync_q;
    logic [1:0] sync_d;
    logic       pressed;

    assign sync_d  = {sync_q[0], key_if.key_in};
    assign pressed = ~sync_q[1];

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_level_q, key_level_d;
    logic             key_press_q, key_press_d;
    logic             key_release_q, key_release_d;

    // A reversal always wins over a coincident tick: the filter states test
    // the key level first and only then look at the tick.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        key_level_d   = key_level_q;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pressed) begin
                    state_d = ST_PRESS_FILT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_FILT: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d     = ST_DOWN;
                        key_press_d = 1'b1;
                        key_level_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DOWN: begin
                if (!pressed) begin
                    state_d = ST_RELEASE_FILT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_FILT: begin
                if (pressed) begin
                    state_d = ST_DOWN;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d       = ST_IDLE;
                        key_release_d = 1'b1;
                        key_level_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= 2'b11;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            key_level_q   <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_level_q   <= key_level_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
        end
    end

    assign key_if.key_level   = key_level_q;
    assign key_if.key_press   = key_press_q;
    assign key_if.key_release = key_release_q;

endmodule : key_debounce_us

// File: tb/tb_key_debounce_us.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_us
// Self-checking bench for key_debounce_us with DEBOUNCE_US = 5 and a 100-cycle
// 50 % divider model. A reference model tracks, per cycle, how many 1 us ticks
// the synchronized key has spent disagreeing with the accepted level; the
// scenario tasks compare the DUT against it and against the latency window.
// -----------------------------------------------------------------------------
module tb_key_debounce_us;

    localparam int D      = 5;
    localparam int LAT_MIN = 403;
    localparam int LAT_MAX = 503;

    logic clk;
    logic rst;
    bit   div_run;
    int   div_ph;

    int checks;
    int errors;

    key_debounce_us_if kif ();

    key_debounce_us #(.DEBOUNCE_US(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .key_if (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: 100-cycle period, high for 50, changes away from posedge.
    always @(negedge clk) begin
        if (div_run) begin
            div_ph     = (div_ph + 1) % 100;
            kif.clk_1m = (div_ph < 50);
        end else begin
            kif.clk_1m = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    // The key must be seen (after two synchronizer stages) disagreeing with
    // the accepted level for one full cycle before ticks start counting; the
    // D-th counted tick flips the level. Any agreement discards the count.
    bit m_s1, m_s2, m_prev1m, m_level, m_press, m_rel, m_armed;
    bit m_tick, m_pressed;
    int m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_prev1m = 1'b0;
            m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0;
            m_cnt = 0; m_armed = 1'b0;
        end else begin
            m_tick    = kif.clk_1m && !m_prev1m;
            m_pressed = !m_s2;
            m_press   = 1'b0;
            m_rel     = 1'b0;
            if (m_pressed != m_level) begin
                if (m_armed && m_tick) m_cnt++;
                if (m_cnt == D) begin
                    m_level = m_pressed;
                    m_press = m_pressed;
                    m_rel   = !m_pressed;
                    m_cnt   = 0;
                    m_armed = 1'b0;
                end else begin
                    m_armed = 1'b1;
                end
            end else begin
                m_armed = 1'b0;
                m_cnt   = 0;
            end
            m_s2     = m_s1;
            m_s1     = kif.key_in;
            m_prev1m = kif.clk_1m;
        end
    end

    // ---------------- tallies collected while running ----------------
    int cyc;
    int t_dp, t_dp_at, t_dr, t_dr_at, t_mp, t_mp_at, t_mr, t_mr_at;
    int t_both, t_lvl_diff;

    task automatic clear_tally();
        t_dp = 0; t_dp_at = -1; t_dr = 0; t_dr_at = -1;
        t_mp = 0; t_mp_at = -1; t_mr = 0; t_mr_at = -1;
        t_both = 0; t_lvl_diff = 0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (kif.key_press)   begin t_dp++; t_dp_at = cyc; end
            if (kif.key_release) begin t_dr++; t_dr_at = cyc; end
            if (m_press)         begin t_mp++; t_mp_at = cyc; end
            if (m_rel)           begin t_mr++; t_mr_at = cyc; end
            if (kif.key_press && kif.key_release) t_both++;
            if (kif.key_level !== m_level) t_lvl_diff++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        kif.key_in = 1'b1;
        clear_tally();
        run_cycles(3);
        checks++;
        if (kif.key_level !== 1'b0) begin errors++; $display("FAIL reset_level: got %0b expected 0", kif.key_level); end
        checks++;
        if (kif.key_press !== 1'b0) begin errors++; $display("FAIL reset_press: got %0b expected 0", kif.key_press); end
        checks++;
        if (kif.key_release !== 1'b0) begin errors++; $display("FAIL reset_release: got %0b expected 0", kif.key_release); end
        rst = 1'b0;
        clear_tally();
        run_cycles(2000);
        checks++;
        if (t_dp + t_dr != 0) begin errors++; $display("FAIL reset_idle_strobes: got %0d expected 0", t_dp + t_dr); end
        checks++;
        if (kif.key_level !== 1'b0) begin errors++; $display("FAIL reset_idle_level: got %0b expected 0", kif.key_level); end
    endtask

    task automatic test_clean_press();
        int c0;
        run_cycles($urandom_range(0, 99));
        clear_tally();
        kif.key_in = 1'b0;
        c0 = cyc;
        run_cycles(1000);
        checks++;
        if (t_dp != 1) begin errors++; $display("FAIL press_count: got %0d expected 1", t_dp); end
        checks++;
        if (t_dp_at - c0 < LAT_MIN || t_dp_at - c0 > LAT_MAX) begin
            errors++; $display("FAIL press_delay: got %0d required %0d..%0d", t_dp_at - c0, LAT_MIN, LAT_MAX);
        end
        checks++;
        if (t_dp_at != t_mp_at) begin errors++; $display("FAIL press_vs_model: got cycle %0d expected %0d", t_dp_at, t_mp_at); end
        checks++;
        if (kif.key_level !== 1'b1 || t_lvl_diff != 0) begin
            errors++; $display("FAIL press_level: got %0b (%0d level diffs) expected 1 (0)", kif.key_level, t_lvl_diff);
        end
        checks++;
        if (t_dr != 0) begin errors++; $display("FAIL press_no_release: got %0d expected 0", t_dr); end
    endtask

    task automatic test_release();
        int c0;
        // clean release from DOWN
        run_cycles($urandom_range(0, 99));
        clear_tally();
        kif.key_in = 1'b1;
        c0 = cyc;
        run_cycles(1000);
        checks++;
        if (t_dr != 1 || t_dp != 0) begin errors++; $display("FAIL release_count: got %0d/%0d expected 1/0", t_dr, t_dp); end
        checks++;
        if (t_dr_at - c0 < LAT_MIN || t_dr_at - c0 > LAT_MAX) begin
            errors++; $display("FAIL release_delay: got %0d required %0d..%0d", t_dr_at - c0, LAT_MIN, LAT_MAX);
        end
        checks++;
        if (kif.key_level !== 1'b0 || t_lvl_diff != 0) begin
            errors++; $display("FAIL release_level: got %0b (%0d level diffs) expected 0 (0)", kif.key_level, t_lvl_diff);
        end
        // press again, then release with a 1-cycle 0-glitch in the filter
        kif.key_in = 1'b0;
        run_cycles(1000);
        clear_tally();
        kif.key_in = 1'b1;
        run_cycles(250);
        kif.key_in = 1'b0;
        run_cycles(1);
        kif.key_in = 1'b1;
        c0 = cyc;
        run_cycles(1000);
        checks++;
        if (t_dr != 1) begin errors++; $display("FAIL glitch_release_count: got %0d expected 1", t_dr); end
        checks++;
        if (t_dr_at - c0 < LAT_MIN || t_dr_at - c0 > LAT_MAX) begin
            errors++; $display("FAIL glitch_release_delay: got %0d required %0d..%0d", t_dr_at - c0, LAT_MIN, LAT_MAX);
        end
        checks++;
        if (t_dr_at != t_mr_at || t_dp != 0) begin
            errors++; $display("FAIL glitch_release_model: got cycle %0d presses %0d expected %0d 0", t_dr_at, t_dp, t_mr_at);
        end
    endtask

    task automatic test_bounce();
        int c0;
        run_cycles($urandom_range(0, 99));
        clear_tally();
        for (int e = 0; e < 4; e++) begin
            kif.key_in = ~kif.key_in;
            run_cycles(150);
        end
        checks++;
        if (t_dp + t_dr != 0) begin errors++; $display("FAIL bounce_strobes: got %0d expected 0", t_dp + t_dr); end
        kif.key_in = 1'b0;
        c0 = cyc;
        run_cycles(1000);
        checks++;
        if (t_dp != 1) begin errors++; $display("FAIL bounce_press_count: got %0d expected 1", t_dp); end
        checks++;
        if (t_dp_at - c0 < LAT_MIN || t_dp_at - c0 > LAT_MAX) begin
            errors++; $display("FAIL bounce_press_delay: got %0d required %0d..%0d", t_dp_at - c0, LAT_MIN, LAT_MAX);
        end
        kif.key_in = 1'b1;
        run_cycles(1000);
        checks++;
        if (kif.key_level !== 1'b0 || t_dr != 1) begin
            errors++; $display("FAIL bounce_release: got level %0b releases %0d expected 0 1", kif.key_level, t_dr);
        end
        // short glitch from IDLE
        clear_tally();
        kif.key_in = 1'b0;
        run_cycles(50);
        kif.key_in = 1'b1;
        run_cycles(1000);
        checks++;
        if (t_dp + t_dr != 0 || kif.key_level !== 1'b0) begin
            errors++; $display("FAIL glitch_idle: got strobes %0d level %0b expected 0 0", t_dp + t_dr, kif.key_level);
        end
    endtask

    task automatic test_reset_mid_filter();
        int  c0;
        bit  seen;
        run_cycles($urandom_range(0, 99));
        clear_tally();
        kif.key_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            run_cycles(1);
            if (m_cnt == 3) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL midfilt_wait: got no 3rd tick expected within 1000 cycles"); end
        run_cycles(10);
        rst = 1'b1;
        run_cycles(3);
        checks++;
        if (kif.key_level !== 1'b0 || kif.key_press !== 1'b0 || kif.key_release !== 1'b0 || t_dp != 0) begin
            errors++; $display("FAIL midfilt_reset_outputs: got %0b%0b%0b presses %0d expected 000 0",
                               kif.key_level, kif.key_press, kif.key_release, t_dp);
        end
        rst = 1'b0;
        c0 = cyc;
        clear_tally();
        run_cycles(1000);
        checks++;
        if (t_dp != 1) begin errors++; $display("FAIL midfilt_press_count: got %0d expected 1", t_dp); end
        checks++;
        if (t_dp_at - c0 < LAT_MIN || t_dp_at - c0 > LAT_MAX) begin
            errors++; $display("FAIL midfilt_press_delay: got %0d required %0d..%0d", t_dp_at - c0, LAT_MIN, LAT_MAX);
        end
        kif.key_in = 1'b1;
        run_cycles(1000);
        checks++;
        if (t_dr != 1 || kif.key_level !== 1'b0) begin
            errors++; $display("FAIL midfilt_release: got %0d level %0b expected 1 0", t_dr, kif.key_level);
        end
    endtask

    task automatic test_static_divider();
        div_run = 1'b0;
        run_cycles(5);
        clear_tally();
        kif.key_in = 1'b0;
        run_cycles(10000);
        checks++;
        if (t_dp != 0 || kif.key_level !== 1'b0) begin
            errors++; $display("FAIL static_div: got presses %0d level %0b expected 0 0", t_dp, kif.key_level);
        end
        div_run = 1'b1;
        run_cycles(1000);
        checks++;
        if (t_dp != 1 || kif.key_level !== 1'b1) begin
            errors++; $display("FAIL static_div_resume: got presses %0d level %0b expected 1 1", t_dp, kif.key_level);
        end
        kif.key_in = 1'b1;
        run_cycles(1000);
    endtask

    task automatic test_random();
        int hold;
        for (int s = 0; s < 40; s++) begin
            kif.key_in = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(450, 900)) : int'($urandom_range(1, 120));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                cyc++;
                checks++;
                if (kif.key_level !== m_level || kif.key_press !== m_press || kif.key_release !== m_rel) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL random_cycle%0d: got lvl/prs/rel %0b%0b%0b expected %0b%0b%0b",
                                 cyc, kif.key_level, kif.key_press, kif.key_release, m_level, m_press, m_rel);
                end
                checks++;
                if (kif.key_press && kif.key_release) begin
                    errors++; $display("FAIL random_both_strobes: got 1 expected 0 at cycle %0d", cyc);
                end
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        div_ph     = 0;
        div_run    = 1'b1;
        rst        = 1'b1;
        kif.key_in = 1'b1;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_reset_mid_filter();
        test_static_divider();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_key_debounce_us
